// File: rtl/mio_bus.sv
// mio_bus: CPU data-side responder for synchronous RAM, LEDs, switches and timer.
// Define MIO_TIMER_EN to build the down-counter timer at 0xF000_0008.
module mio_bus #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        dm_ctrl,
    output logic [31:0]       rdata,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              timer_irq
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [31:0] LED_A = 32'hF000_0000;
    localparam logic [31:0] SW_A  = 32'hF000_0004;
    localparam logic [31:0] TMR_A = 32'hF000_0008;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;

    logic is_half, is_byte, is_ram;
    logic hit_led, hit_sw, hit_tmr;
    logic misal, err, ram_ld, req;

    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  c
    );
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? w[31:16] : w[15:0];
        b = w[{off, 3'b000} +: 8];
        case (c)
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b010:  fmt_load = {16'h0, h};
            3'b011:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'h0, b};
            default: fmt_load = w;
        endcase
    endfunction

    always_comb begin
        is_half = (dm_ctrl == 3'b001) || (dm_ctrl == 3'b010);
        is_byte = (dm_ctrl == 3'b011) || (dm_ctrl == 3'b100);
        is_ram  = (addr[31:28] == 4'h0);
        hit_led = (addr == LED_A);
        hit_sw  = (addr == SW_A);
`ifdef MIO_TIMER_EN
        hit_tmr = (addr == TMR_A);
`else
        hit_tmr = 1'b0;
`endif
        // peripherals are matched by exact word address, so only RAM can be misaligned
        misal  = is_ram & ((is_half & addr[0]) |
                 (~is_half & ~is_byte & (|addr[1:0])));
        err    = misal | ~(is_ram | hit_led | hit_sw | hit_tmr);
        ram_ld = is_ram & ~misal & ~mem_w;
        req    = (state_q == IDLE) & CPU_MIO;
    end

`ifdef MIO_TIMER_EN
    logic [31:0] cnt_q, cnt_d;
    logic        irq_q, irq_d;
    logic        tmr_wr;

    assign tmr_wr = req & mem_w & hit_tmr;

    always_comb begin
        cnt_d = cnt_q;
        irq_d = 1'b0;
        if (tmr_wr) begin
            cnt_d = wdata;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
            irq_d = (cnt_q == 32'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    state_d = ram_ld ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // result registers only change on the way into RESP, so rdata holds otherwise
    always_comb begin
        rdata_d = rdata_q;
        err_d   = 1'b0;
        led_d   = led_q;
        unique case (state_q)
            IDLE: begin
                if (CPU_MIO && !ram_ld) begin
                    err_d   = err;
                    rdata_d = '0;
                    if (!mem_w && !err) begin
                        if (hit_led) rdata_d = {16'h0, led_q};
                        if (hit_sw)  rdata_d = {16'h0, sw_in};
`ifdef MIO_TIMER_EN
                        if (hit_tmr) rdata_d = cnt_q;
`endif
                    end
                    if (mem_w && hit_led) led_d = wdata[15:0];
                end
            end
            RD_WAIT: rdata_d = fmt_load(ram_rdata, addr[1:0], dm_ctrl);
            default: ;
        endcase
    end

    always_comb begin
        ram_en = 1'b0;
        ram_we = 4'b0000;
        if (req && is_ram && !misal) begin
            ram_en = 1'b1;
            if (mem_w) begin
                if (is_byte)      ram_we = 4'b0001 << addr[1:0];
                else if (is_half) ram_we = addr[1] ? 4'b1100 : 4'b0011;
                else              ram_we = 4'b1111;
            end
        end
    end

    always_comb begin
        if (is_byte)      ram_wdata = {4{wdata[7:0]}};
        else if (is_half) ram_wdata = {2{wdata[15:0]}};
        else              ram_wdata = wdata;
    end

    assign ram_addr  = addr[RAM_AW+1:2];
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign MIO_ready = (state_q == RESP);
    assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: directed bench for mio_bus with a byte-level memory/peripheral model.
// Expectations follow MIO_TIMER_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_mio_bus;

    localparam int AW = 10;

`ifdef MIO_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          CPU_MIO = 1'b0;
    logic          mem_w = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [2:0]    dm_ctrl = '0;
    logic [31:0]   rdata;
    logic          MIO_ready;
    logic          bus_err;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [15:0]   sw_in = '0;
    logic [15:0]   led_out;
    logic          timer_irq;

    mio_bus #(.RAM_AW(AW)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .dm_ctrl(dm_ctrl), .rdata(rdata),
        .MIO_ready(MIO_ready), .bus_err(bus_err), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // board RAM with registered read
    logic [31:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram[ram_addr];
            for (int l = 0; l < 4; l++)
                if (ram_we[l]) ram[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
        end
    end

    // model state
    logic [7:0]  mem_m [0:4095];
    logic [15:0] led_m;
    int          tw_edge, tw_val;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    int          irq_seen = 0;

    bit          pending = 0, done = 0, exp_err = 0, chk_rd = 0;
    int          ready_at = 0;
    logic [31:0] exp_rd = '0, got_rd = '0;
    logic        got_err = 1'b0;
    string       cur = "";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int tcount(input int c);
        if (tw_val > 0 && (c - tw_edge) < tw_val) return tw_val - (c - tw_edge);
        return 0;
    endfunction

    function automatic bit exp_irq(input int c);
        return (tw_val > 0) && (c - tw_edge == tw_val);
    endfunction

    always @(negedge clk) begin
        if (pending && cyc == ready_at) begin
            chk({cur, " ready"}, MIO_ready, 1);
            chk({cur, " bus_err"}, bus_err, exp_err);
            if (chk_rd) chk({cur, " rdata"}, rdata, exp_rd);
            got_rd  = rdata;
            got_err = bus_err;
            pending = 0;
            done    = 1;
        end else begin
            chk("no ready", MIO_ready, 0);
            chk("no bus_err", bus_err, 0);
        end
        chk("timer_irq", timer_irq, exp_irq(cyc));
        if (timer_irq) irq_seen++;
    end

    task automatic access(input string nm, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
        int          sz, b;
        bit          ram_hit, mis, mapped, err, ld;
        logic [3:0]  we_e;
        logic [31:0] v, wd_e;
        @(negedge clk);
        #1;
        sz = (c == 3'd1 || c == 3'd2) ? 2 : (c == 3'd3 || c == 3'd4) ? 1 : 4;
        ram_hit = (a[31:28] == 4'h0);
        mis     = ram_hit && ((int'(a[1:0]) % sz) != 0);
        mapped  = ram_hit || a == 32'hF000_0000 || a == 32'hF000_0004 ||
                  (TMR && a == 32'hF000_0008);
        err     = mis || !mapped;
        ld      = ram_hit && !mis && !w;
        b       = int'(a[11:0]);
        we_e    = '0;
        if (ram_hit && !mis && w)
            for (int i = 0; i < sz; i++) we_e[(b + i) % 4] = 1'b1;
        wd_e = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
        v = '0;
        if (!err && !w) begin
            if (ram_hit) begin
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[b + i];
                if (c == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
                if (c == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
            end else if (a == 32'hF000_0000) v = {16'h0, led_m};
            else if (a == 32'hF000_0004)     v = {16'h0, sw_in};
            else                             v = tcount(cyc);
        end
        exp_rd   = v;
        exp_err  = err;
        chk_rd   = !w || err;
        cur      = nm;
        done     = 0;
        ready_at = cyc + (ld ? 2 : 1);
        pending  = 1;
        if (w && !err) begin
            if (ram_hit)
                for (int i = 0; i < sz; i++) mem_m[b + i] = d[8*i +: 8];
            else if (a == 32'hF000_0000) led_m = d[15:0];
            else if (a == 32'hF000_0008) begin
                tw_edge = cyc + 1;
                tw_val  = int'(d);
            end
        end
        addr = a; wdata = d; dm_ctrl = c; mem_w = w; CPU_MIO = 1'b1;
        #1;
        chk({nm, " ram_en"}, ram_en, ram_hit && !mis);
        chk({nm, " ram_we"}, ram_we, we_e);
        if (we_e != 4'b0) begin
            chk({nm, " ram_addr"}, ram_addr, a[11:2]);
            chk({nm, " ram_wdata"}, ram_wdata, wd_e);
        end
        @(negedge clk);
        #2;
        chk({nm, " one-shot"}, {ram_en, ram_we}, 5'b0);
        for (int k = 0; k < 6 && !done; k++) begin
            @(negedge clk);
            #2;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for MIO_ready", nm);
            pending = 0;
        end
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        chk({nm, " led_out"}, led_out, led_m);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_m[i] = '0;
        led_m = '0; tw_edge = 0; tw_val = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst rdata", rdata, 0);
        chk("rst ready", MIO_ready, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst led", led_out, 0);
        chk("rst irq", timer_irq, 0);
        chk("rst ram_en/we", {ram_en, ram_we}, 5'b0);
        reset = 1'b1;

        access("sb 0x5", 1, 32'h5, 32'hAB, 3'b011);
        access("lw 0x4", 0, 32'h4, 0, 3'b000);
        chk("lw 0x4 lit", got_rd, 32'h0000AB00);
        access("sw 0x0", 1, 32'h0, 32'h0000_8001, 3'b000);
        access("lh 0x0", 0, 32'h0, 0, 3'b001);
        chk("lh lit", got_rd, 32'hFFFF8001);
        access("lhu 0x0", 0, 32'h0, 0, 3'b010);
        chk("lhu lit", got_rd, 32'h00008001);
        access("lbu 0x1", 0, 32'h1, 0, 3'b100);
        chk("lbu lit", got_rd, 32'h00000080);
        access("lb 0x1", 0, 32'h1, 0, 3'b011);
        chk("lb lit", got_rd, 32'hFFFFFF80);
        access("lw 0x2 mis", 0, 32'h2, 0, 3'b000);
        chk("lw mis rdata lit", got_rd, 0);
        chk("lw mis err lit", got_err, 1);
        access("sh 0x3 mis", 1, 32'h3, 32'h1111, 3'b001);
        access("sw 0x1 mis", 1, 32'h1, 32'h2222_2222, 3'b000);
        access("sh 0x2", 1, 32'h2, 32'hBEEF, 3'b010);
        access("sb 0x7", 1, 32'h7, 32'h5A, 3'b100);
        access("lw 0x0", 0, 32'h0, 0, 3'b000);
        chk("lw 0x0 lit", got_rd, 32'hBEEF8001);
        access("ld ctrl7", 0, 32'h4, 0, 3'b111);
        chk("ctrl7 lit", got_rd, 32'h5A00AB00);

        access("led wr", 1, 32'hF000_0000, 32'h1234_5678, 3'b000);
        chk("led lit", led_out, 16'h5678);
        access("led rd", 0, 32'hF000_0000, 0, 3'b011);
        chk("led rd lit", got_rd, 32'h00005678);
        sw_in = 16'h00F0;
        access("sw rd", 0, 32'hF000_0004, 0, 3'b000);
        chk("sw rd lit", got_rd, 32'h000000F0);
        access("sw wr", 1, 32'hF000_0004, 32'hFFFF, 3'b000);
        access("unmapped rd", 0, 32'hE000_0000, 0, 3'b000);
        chk("unmapped err lit", got_err, 1);
        access("unmapped wr", 1, 32'hF000_000C, 32'h1, 3'b000);
        access("periph off", 0, 32'hF000_0001, 0, 3'b000);

        irq_seen = 0;
        access("tmr wr 3", 1, 32'hF000_0008, 32'd3, 3'b000);
        chk("tmr wr err lit", got_err, !TMR);
        access("tmr rd", 0, 32'hF000_0008, 0, 3'b000);
        chk("tmr rd lit", got_rd, TMR ? 32'd2 : 32'd0);
        repeat (6) @(negedge clk);
        chk("irq count", irq_seen, TMR ? 1 : 0);
        access("tmr wr 2", 1, 32'hF000_0008, 32'd2, 3'b000);
        access("tmr wr 7", 1, 32'hF000_0008, 32'd7, 3'b000);
        access("tmr wr 0", 1, 32'hF000_0008, 32'd0, 3'b000);
        repeat (10) @(negedge clk);
        chk("irq count after", irq_seen, TMR ? 1 : 0);
        access("tmr rd stop", 0, 32'hF000_0008, 0, 3'b000);
        chk("tmr stop lit", got_rd, 0);

        @(negedge clk);
        #1;
        addr = 32'h0; mem_w = 1'b0; dm_ctrl = 3'b000; CPU_MIO = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0; CPU_MIO = 1'b0;
        led_m = '0; tw_val = 0;
        #1;
        chk("midrst rdata", rdata, 0);
        chk("midrst ready", MIO_ready, 0);
        chk("midrst bus_err", bus_err, 0);
        chk("midrst led", led_out, 0);
        chk("midrst ram", {ram_en, ram_we}, 5'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        access("lw after rst", 0, 32'h0, 0, 3'b000);
        chk("lw after rst lit", got_rd, 32'hBEEF8001);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_bus.md
# mio_bus

Memory/IO bus responder serving the single-cycle CPU's data-side requests (`CPU_MIO`, `mem_w`, address, write data, `dm_ctrl`) and returning read data with an `MIO_ready` handshake. It decodes each access to a synchronous data RAM or to on-chip peripherals (LED register, switch input, down-counter timer). It performs sub-word lane steering, byte enables and load sign/zero extension. It sits between the CPU core and the RAM/board IO, and its timer interrupt feeds the core's `INT` input.

## Interface
- `RAM_AW`, default 10: RAM word-address width (4 KiB).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `CPU_MIO`  in  1  access request; held stable with all request fields until `MIO_ready`.
- `mem_w`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the value sits in bits [7:0] or [15:0] for sub-word stores.
- `dm_ctrl`  in  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes are treated as word.
- `rdata`  out  32  formatted load data, valid while `MIO_ready`=1.
- `MIO_ready`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  pulses with `MIO_ready` on a misaligned or unmapped access.
- `ram_en`  out  1 / `ram_we`  out  4 / `ram_addr`  out  RAM_AW / `ram_wdata`  out  32  synchronous RAM port; read data is registered by the RAM.
- `ram_rdata`  in  32  RAM read data, valid one cycle after `ram_en`.
- `sw_in`  in  16  board switches.
- `led_out`  out  16  LED register.
- `timer_irq`  out  1  one-cycle timer expiry pulse.

## Operation
- Address map:
  - RAM at `addr[31:28]`=0, using `ram_addr`=`addr[RAM_AW+1:2]`.
  - `0xF000_0000` LED register: R/W, uses bits [15:0].
  - `0xF000_0004` switches: read-only, zero-extended; writes are dropped.
  - `0xF000_0008` timer: a read returns the count, a write loads it.
  - All other addresses are unmapped: reads return 0, writes are dropped, `bus_err`=1.
- Alignment:
  - Word accesses need `addr[1:0]`=0.
  - Half accesses need `addr[0]`=0.
  - A misaligned access completes with no write, `rdata`=0 and `bus_err`=1.
- Store lanes:
  - Byte: `ram_we`=1<<`addr[1:0]`, with `wdata[7:0]` replicated across all four lanes.
  - Half: `ram_we`=0011 or 1100, selected by `addr[1]`, with `wdata[15:0]` replicated.
  - Word: `ram_we`=1111.
- Loads:
  - The byte or half is selected by `addr[1:0]`, then sign- or zero-extended per `dm_ctrl`.
  - Peripheral registers are accessed as whole words; `dm_ctrl` is ignored for them.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE, on `CPU_MIO`=1 with an aligned RAM load: assert `ram_en` and go to RD_WAIT.
  - IDLE, on any other request: perform the write or peripheral read in that cycle, register the result, go to RESP.
  - RD_WAIT: capture and format `ram_rdata`, go to RESP.
  - RESP: `MIO_ready`=1 for one cycle, then return to IDLE unconditionally.
  - A request still high in that IDLE cycle is a new access. The CPU must drop `CPU_MIO` or change the request after ready.
- Timer:
  - A 32-bit down-counter that decrements each cycle while nonzero.
  - A transition 1→0 pulses `timer_irq` for one cycle.
  - A write loads the counter in the IDLE cycle and overrides that cycle's decrement. A write of 0 stops the counter without an irq.

## Timing
- Request sampled in IDLE at edge N:
  - RAM load: `MIO_ready` is high in cycle N+2.
  - Store or peripheral access: `MIO_ready` is high in cycle N+1.
- `rdata` and `bus_err` are registered and valid only while `MIO_ready`=1; `rdata` holds its last value otherwise.
- `ram_en` and `ram_we` are combinational from IDLE plus the request, and last exactly one cycle per access.
- Reset (async assert, sync release) returns everything to its initial value:
  - FSM goes to IDLE.
  - `MIO_ready`, `bus_err`, `timer_irq`, `ram_en`, `ram_we` all return to 0.
  - `rdata`, `led_out` and the counter return to 0.
  - An access in flight is abandoned with no ready pulse.
- If the timer expires and a timer write occurs in the same cycle, the write wins and no irq is produced.

## Configuration
- `MIO_TIMER_EN` defined: the timer is built at `0xF000_0008`.
- `MIO_TIMER_EN` undefined: the timer is not built.
  - `0xF000_0008` is treated as unmapped: `bus_err`=1, reads return 0.
  - `timer_irq` is tied to 0.

## Test plan
- Store byte: `addr`=0x0000_0005, `wdata`=0xAB, `dm_ctrl`=011 → `ram_we`=0010 and `ram_wdata`=0xABABABAB. A following `lw` at 0x4 returns byte1=0xAB, with ready at N+2.
- RAM word 0x0000_8001 at address 0x0: `lh` at 0x0 (001) → 0xFFFF8001; `lhu` at 0x0 (010) → 0x00008001; `lbu` at 0x1 → 0x00000080.
- Misaligned access: `lw` at 0x0000_0002 → `rdata`=0, `bus_err`=1, no `ram_en`. `sh` at 0x3 → `ram_we` stays 0.
- Peripherals:
  - Write 0x1234_5678 to `0xF000_0000` → `led_out`=0x5678.
  - With `sw_in`=0x00F0, a read of `0xF000_0004` → 0x000000F0, ready at N+1.
  - A read of `0xE000_0000` → 0 with `bus_err`=1.
- Timer (with `MIO_TIMER_EN`): write 3 to `0xF000_0008` → the count reads 3,2,1,0 on successive cycles and `timer_irq` pulses once as the count reaches 0. Without the macro, the same write gives `bus_err`=1 and no irq.
- Reset mid-access: assert `reset` low in RD_WAIT → outputs go to 0 immediately and no `MIO_ready` follows. After release, a new `lw` completes normally.
